// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (inc && !(&count))
      count <= count + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / redirect / memory-wait hazard control for the 5-stage core.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             UseRt_ID,
  input  logic             Jump_ID,
  input  logic [4:0]       rt_EX,
  input  logic             MemRead_EX,
  input  logic             BranchTaken_EX,
  input  logic             MemAccess_MEM,
  input  logic             mem_ready,
  output logic             hold_PC,
  output logic             hold_IFID,
  output logic             hold_IDEX,
  output logic             hold_EXMEM,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  state_t        state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic          timeout_nx;
  logic          pending, memwait, loaduse, redirect;

  assign pending  = MemAccess_MEM & !mem_ready;
  assign memwait  = pending & (state == RUN || wait_cnt < WMAX);
  assign redirect = BranchTaken_EX;
  assign loaduse  = MemRead_EX & (rt_EX != ZERO_REG)
                  & ((rt_EX == rs_ID) | (UseRt_ID & (rt_EX == rt_ID)));

  // Priority ordering: memory wait freezes everything, a redirect
  // squashes the dependent instruction, so it beats load-use.
  always_comb begin
    hold_PC    = 1'b0;
    hold_IFID  = 1'b0;
    hold_IDEX  = 1'b0;
    hold_EXMEM = 1'b0;
    flush_IFID = 1'b0;
    flush_IDEX = 1'b0;
    if (!reset) begin
      if (memwait) begin
        hold_PC    = 1'b1;
        hold_IFID  = 1'b1;
        hold_IDEX  = 1'b1;
        hold_EXMEM = 1'b1;
      end else if (redirect) begin
        flush_IFID = 1'b1;
        flush_IDEX = 1'b1;
      end else if (loaduse) begin
        hold_PC    = 1'b1;
        hold_IFID  = 1'b1;
        flush_IDEX = 1'b1;
      end else if (Jump_ID) begin
        flush_IFID = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    wait_nx    = wait_cnt;
    timeout_nx = mem_timeout;
    case (state)
      RUN: begin
        if (pending) begin
          state_nx = WAIT;
          wait_nx  = WW'(1);
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_nx = RUN;
          wait_nx  = '0;
        end else if (wait_cnt == WMAX) begin
          timeout_nx = 1'b1;
          state_nx   = RUN;
          wait_nx    = '0;
        end else begin
          wait_nx = wait_cnt + WW'(1);
        end
      end
      default: begin
        state_nx = RUN;
        wait_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_nx;
      mem_timeout <= timeout_nx;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hold_PC),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_IFID | flush_IDEX),
    .count (flush_cnt)
  );

endmodule
